writeback: RTL

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback_pkg.sv | 22 ++
 rtl/wb_vec_buffer.sv | 61 ++++++
 rtl/writeback.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - shared widths, depths and types for the writeback stage
package writeback_pkg;
    localparam int REG_WIDTH      = 16;
    localparam int VREG_LANES     = 4;
    localparam int VREG_WIDTH     = VREG_LANES * REG_WIDTH;
    localparam int VREG_ID_WIDTH  = 6;
    localparam int REG_ID_WIDTH   = 4;
    localparam int PC_WIDTH       = 16;
    localparam int OPCODE_WIDTH   = 8;
    localparam int IR_WIDTH       = 32;
    localparam int CC_WIDTH       = 3;
    localparam int CNT_WIDTH      = 16;
    localparam int WB_VBUF_DEPTH  = 2;
    localparam int NUM_REGS       = 1 << REG_ID_WIDTH;
    localparam int NUM_VREGS      = 1 << VREG_ID_WIDTH;
    localparam int VBUF_CNT_WIDTH = $clog2(WB_VBUF_DEPTH + 1);

    typedef struct packed {
        logic [VREG_ID_WIDTH-1:0] idx;
        logic [VREG_WIDTH-1:0]    value;
    } vwr_t;
endpackage

// File: rtl/wb_vec_buffer.sv
// rtl/wb_vec_buffer.sv - small ordered FIFO holding vector writes while the VRF is busy
module wb_vec_buffer
    import writeback_pkg::*;
(
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      push,
    input  logic                      pop,
    input  vwr_t                      wdata,
    output logic [VBUF_CNT_WIDTH-1:0] count,
    output vwr_t                      head,
    output vwr_t                      tail
);
    vwr_t                      ent_q [WB_VBUF_DEPTH];
    vwr_t                      ent_d [WB_VBUF_DEPTH];
    logic [VBUF_CNT_WIDTH-1:0] cnt_q;
    logic [VBUF_CNT_WIDTH-1:0] cnt_d;
    logic [VBUF_CNT_WIDTH-1:0] wr_pos;

    // Entry 0 is always the head; a pop shifts everything down one slot.
    always_comb begin
        ent_d  = ent_q;
        wr_pos = cnt_q - VBUF_CNT_WIDTH'(pop);
        if (pop) begin
            for (int i = 0; i < WB_VBUF_DEPTH - 1; i++) begin
                ent_d[i] = ent_q[i+1];
            end
            ent_d[WB_VBUF_DEPTH-1] = '0;
        end
        for (int i = 0; i < WB_VBUF_DEPTH; i++) begin
            if (push && (VBUF_CNT_WIDTH'(i) == wr_pos)) begin
                ent_d[i] = wdata;
            end
        end
        cnt_d = cnt_q + VBUF_CNT_WIDTH'(push) - VBUF_CNT_WIDTH'(pop);
    end

    always_comb begin
        head = ent_q[0];
        tail = ent_q[0];
        for (int i = 0; i < WB_VBUF_DEPTH; i++) begin
            if (cnt_q == VBUF_CNT_WIDTH'(i + 1)) begin
                tail = ent_q[i];
            end
        end
    end

    assign count = cnt_q;

    always_ff @(negedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < WB_VBUF_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/writeback.sv
// rtl/writeback.sv - writeback stage: scalar RF, CC, vector RF with busy-buffer, retire info
module writeback
    import writeback_pkg::*;
(
    input  logic                     I_CLOCK,
    input  logic                     I_LOCK,
    input  logic                     I_MEM_Valid,
    input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
    input  logic [PC_WIDTH-1:0]      I_PC,
    input  logic [IR_WIDTH-1:0]      I_IR,
    input  logic [REG_ID_WIDTH-1:0]  I_DestRegIdx,
    input  logic [REG_WIDTH-1:0]     I_DestValue,
    input  logic                     I_RegWEn,
    input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
    input  logic [VREG_WIDTH-1:0]    I_VecDestValue,
    input  logic                     I_VRegWEn,
    input  logic [CC_WIDTH-1:0]      I_CCValue,
    input  logic                     I_CCWEn,
    input  logic                     I_GPUStallSignal,
    input  logic [REG_ID_WIDTH-1:0]  I_Src1Idx,
    input  logic [REG_ID_WIDTH-1:0]  I_Src2Idx,
    input  logic [VREG_ID_WIDTH-1:0] I_VSrcIdx,
    output logic [REG_WIDTH-1:0]     O_Src1Value,
    output logic [REG_WIDTH-1:0]     O_Src2Value,
    output logic [VREG_WIDTH-1:0]    O_VSrcValue,
    output logic [CC_WIDTH-1:0]      O_CCValue,
    output logic                     O_WB_Stall,
    output logic                     O_VBufOverflow,
    output logic                     O_WB_Valid,
    output logic [REG_ID_WIDTH-1:0]  O_WB_DestRegIdx,
    output logic                     O_WB_RegWEn,
    output logic [CNT_WIDTH-1:0]     O_RetireCount
);
    logic                      retire, vec_wr, buf_empty, buf_full;
    logic                      buf_pop, buf_push, vec_direct, vec_queue, vec_drop;
    logic                      scalar_wr;
    logic [VBUF_CNT_WIDTH-1:0] buf_cnt;
    vwr_t                      buf_head, buf_tail, buf_wdata;
    logic                      unused_ident;

    logic [REG_WIDTH-1:0]    rf_q  [NUM_REGS];
    logic [REG_WIDTH-1:0]    rf_d  [NUM_REGS];
    logic [VREG_WIDTH-1:0]   vrf_q [NUM_VREGS];
    logic [VREG_WIDTH-1:0]   vrf_d [NUM_VREGS];
    logic [CC_WIDTH-1:0]     cc_q, cc_d;
    logic                    ovf_q, ovf_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [REG_ID_WIDTH-1:0] wb_idx_q, wb_idx_d;
    logic                    wb_regwen_q, wb_regwen_d;
    logic [CNT_WIDTH-1:0]    retire_cnt_q, retire_cnt_d;

    assign unused_ident = ^{I_Opcode, I_PC, I_IR};

    // A vector write goes straight to the VRF only if nothing older is still queued.
    always_comb begin
        retire     = I_LOCK & I_MEM_Valid;
        scalar_wr  = retire & I_RegWEn;
        vec_wr     = retire & I_VRegWEn;
        buf_empty  = (buf_cnt == '0);
        buf_full   = (buf_cnt == VBUF_CNT_WIDTH'(WB_VBUF_DEPTH));
        buf_pop    = I_LOCK & ~I_GPUStallSignal & ~buf_empty;
        vec_direct = vec_wr & ~I_GPUStallSignal & buf_empty;
        vec_queue  = vec_wr & ~vec_direct;
        buf_push   = vec_queue & (~buf_full | buf_pop);
        vec_drop   = vec_queue & buf_full & ~buf_pop;
        buf_wdata  = '{idx: I_DestVRegIdx, value: I_VecDestValue};
    end

    wb_vec_buffer u_vbuf (
        .clk    (I_CLOCK),
        .resetn (I_LOCK),
        .push   (buf_push),
        .pop    (buf_pop),
        .wdata  (buf_wdata),
        .count  (buf_cnt),
        .head   (buf_head),
        .tail   (buf_tail)
    );

    always_comb begin
        rf_d  = rf_q;
        vrf_d = vrf_q;
        if (scalar_wr) begin
            rf_d[I_DestRegIdx] = I_DestValue;
        end
        if (buf_pop) begin
            vrf_d[buf_head.idx] = buf_head.value;
        end else if (vec_direct) begin
            vrf_d[I_DestVRegIdx] = I_VecDestValue;
        end
        cc_d         = (retire && I_CCWEn) ? I_CCValue : cc_q;
        ovf_d        = ovf_q | vec_drop;
        wb_valid_d   = retire;
        wb_idx_d     = retire ? I_DestRegIdx : '0;
        wb_regwen_d  = scalar_wr;
        retire_cnt_d = retire_cnt_q + CNT_WIDTH'(retire);
    end

    // Reads see the newest value: incoming retire, then buffer tail, head, then VRF.
    always_comb begin
        O_Src1Value = (scalar_wr && (I_Src1Idx == I_DestRegIdx)) ? I_DestValue : rf_q[I_Src1Idx];
        O_Src2Value = (scalar_wr && (I_Src2Idx == I_DestRegIdx)) ? I_DestValue : rf_q[I_Src2Idx];
        if (vec_wr && (I_VSrcIdx == I_DestVRegIdx)) begin
            O_VSrcValue = I_VecDestValue;
        end else if (!buf_empty && (buf_tail.idx == I_VSrcIdx)) begin
            O_VSrcValue = buf_tail.value;
        end else if (!buf_empty && (buf_head.idx == I_VSrcIdx)) begin
            O_VSrcValue = buf_head.value;
        end else begin
            O_VSrcValue = vrf_q[I_VSrcIdx];
        end
    end

    assign O_CCValue       = cc_q;
    assign O_WB_Stall      = buf_full;
    assign O_VBufOverflow  = ovf_q;
    assign O_WB_Valid      = wb_valid_q;
    assign O_WB_DestRegIdx = wb_idx_q;
    assign O_WB_RegWEn     = wb_regwen_q;
    assign O_RetireCount   = retire_cnt_q;

    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
            for (int i = 0; i < NUM_VREGS; i++) begin
                vrf_q[i] <= '0;
            end
            cc_q         <= '0;
            ovf_q        <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_idx_q     <= '0;
            wb_regwen_q  <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            rf_q         <= rf_d;
            vrf_q        <= vrf_d;
            cc_q         <= cc_d;
            ovf_q        <= ovf_d;
            wb_valid_q   <= wb_valid_d;
            wb_idx_q     <= wb_idx_d;
            wb_regwen_q  <= wb_regwen_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end
endmodule
